fc_act_requant_buf: RTL

- Downstream neighbour of the fully-connected node stage.
- Accepts one signed 32-bit accumulator result per node and applies optional ReLU.
- Requantises each result with a rounding arithmetic right shift and saturation to int8, then stores it in an activation buffer of NODES entries.
- The buffer is read by the next layer's node stage; the block also tracks argmax and a saturation count per layer.

---
 rtl/fc_act_requant_buf_pkg.sv | 26 ++
 rtl/fc_act_requant_buf_requant_sat_pipe.sv | 90 +++++++++
 rtl/fc_act_requant_buf.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/fc_act_requant_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fc_pkg
// Description : Shared sizes, data types and buffer states for the FC
//               activation requantise/buffer block.
// Revision    : 1.0 - initial release
// ============================================================================
package fc_pkg;

    localparam int NODES = 200;
    localparam int ACC_W = 32;
    localparam int OUT_W = 8;
    localparam int IDX_W = $clog2(NODES);

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic signed [OUT_W-1:0] act_t;
    typedef logic [IDX_W-1:0]        idx_t;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

endpackage
`default_nettype wire

// File: rtl/fc_act_requant_buf_requant_sat_pipe.sv
`default_nettype none
// ============================================================================
// Module      : requant_sat_pipe
// Description : Two-stage ReLU / rounding arithmetic shift / int saturation
//               pipeline with valid sideband and a clip flag.
// Revision    : 1.0 - initial release
// ============================================================================
module requant_sat_pipe #(
    parameter int ACC_W = 32,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [ACC_W-1:0] in_acc,
    input  logic [4:0]       cfg_shift,
    input  logic             cfg_relu,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat
);

    // One extra bit keeps acc + rounding constant from overflowing.
    localparam int EXT_W = ACC_W + 1;
    localparam logic signed [EXT_W-1:0] SAT_HI = EXT_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [EXT_W-1:0] SAT_LO = EXT_W'(-(2 ** (OUT_W - 1)));

    logic             s1_valid_q, s1_valid_d;
    logic [ACC_W-1:0] s1_acc_q,   s1_acc_d;
    logic [4:0]       s1_shift_q, s1_shift_d;
    logic             s1_relu_q,  s1_relu_d;
    logic             s2_valid_q, s2_valid_d;
    logic signed [EXT_W-1:0] s2_r_q, s2_r_d;

    logic signed [EXT_W-1:0] acc_ext;
    logic signed [EXT_W-1:0] round_add;
    logic signed [EXT_W-1:0] sum;

    always_comb begin
        s1_valid_d = in_valid;
        s1_acc_d   = in_acc;
        s1_shift_d = cfg_shift;
        s1_relu_d  = cfg_relu;

        acc_ext   = EXT_W'($signed(s1_acc_q));
        round_add = '0;
        if (s1_shift_q != 5'd0) begin
            round_add = {{(EXT_W-1){1'b0}}, 1'b1} << (s1_shift_q - 5'd1);
        end
        sum        = acc_ext + round_add;
        s2_r_d     = sum >>> s1_shift_q;
        if (s1_relu_q && s1_acc_q[ACC_W-1]) begin
            s2_r_d = '0;
        end
        s2_valid_d = s1_valid_q;
    end

    always_comb begin
        out_valid = s2_valid_q;
        out_sat   = 1'b0;
        out_data  = s2_r_q[OUT_W-1:0];
        if (s2_r_q > SAT_HI) begin
            out_data = SAT_HI[OUT_W-1:0];
            out_sat  = 1'b1;
        end else if (s2_r_q < SAT_LO) begin
            out_data = SAT_LO[OUT_W-1:0];
            out_sat  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_acc_q   <= '0;
            s1_shift_q <= '0;
            s1_relu_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_r_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_acc_q   <= s1_acc_d;
            s1_shift_q <= s1_shift_d;
            s1_relu_q  <= s1_relu_d;
            s2_valid_q <= s2_valid_d;
            s2_r_q     <= s2_r_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fc_act_requant_buf.sv
`default_nettype none
// ============================================================================
// Module      : fc_act_requant_buf
// Description : Requantises FC accumulator results into an int8 activation
//               buffer, tracking argmax and a per-layer clip count.
// Revision    : 1.0 - initial release
// ============================================================================
module fc_act_requant_buf #(
    parameter int NODES = fc_pkg::NODES,
    parameter int ACC_W = fc_pkg::ACC_W,
    parameter int OUT_W = fc_pkg::OUT_W,
    parameter int IDX_W = $clog2(NODES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ACC_W-1:0] in_acc,
    input  logic [4:0]       cfg_shift,
    input  logic             cfg_relu,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [OUT_W-1:0] rd_data,
    input  logic             buf_release,
    output logic             buf_full,
    output logic             layer_done,
    output logic [IDX_W-1:0] max_idx,
    output logic [OUT_W-1:0] max_val,
    output logic [15:0]      sat_count
);

    import fc_pkg::*;

    buf_state_t       state_q,      state_d;
    logic [IDX_W-1:0] acc_cnt_q,    acc_cnt_d;
    logic [IDX_W-1:0] wr_idx_q,     wr_idx_d;
    logic [IDX_W-1:0] max_idx_q,    max_idx_d;
    logic [OUT_W-1:0] max_val_q,    max_val_d;
    logic [OUT_W-1:0] rd_data_q,    rd_data_d;
    logic             buf_full_q,   buf_full_d;
    logic             layer_done_q, layer_done_d;
    logic [15:0]      sat_count_q,  sat_count_d;

    logic [OUT_W-1:0] mem [NODES];

    logic             accept;
    logic             last_accept;
    logic             last_write;
    logic             p_valid;
    logic [OUT_W-1:0] p_data;
    logic             p_sat;

    assign in_ready    = (state_q == FILL);
    assign accept      = in_valid && in_ready;
    assign last_accept = accept && (acc_cnt_q == IDX_W'(NODES - 1));
    assign last_write  = p_valid && (wr_idx_q == IDX_W'(NODES - 1));

    requant_sat_pipe #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept),
        .in_acc    (in_acc),
        .cfg_shift (cfg_shift),
        .cfg_relu  (cfg_relu),
        .out_valid (p_valid),
        .out_data  (p_data),
        .out_sat   (p_sat)
    );

    always_comb begin
        state_d      = state_q;
        acc_cnt_d    = acc_cnt_q;
        wr_idx_d     = wr_idx_q;
        max_idx_d    = max_idx_q;
        max_val_d    = max_val_q;
        buf_full_d   = buf_full_q;
        layer_done_d = 1'b0;
        sat_count_d  = sat_count_q;

        if (accept) begin
            acc_cnt_d = acc_cnt_q + 1'b1;
        end

        if (p_valid) begin
            wr_idx_d = wr_idx_q + 1'b1;
            if (p_sat && (sat_count_q != 16'hFFFF)) begin
                sat_count_d = sat_count_q + 16'd1;
            end
            // Index 0 of a layer always loads; later ties keep the lower index.
            if ((wr_idx_q == '0) || ($signed(p_data) > $signed(max_val_q))) begin
                max_idx_d = wr_idx_q;
                max_val_d = p_data;
            end
        end

        case (state_q)
            FILL: begin
                if (last_accept) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last_write) begin
                    state_d      = FULL;
                    layer_done_d = 1'b1;
                    buf_full_d   = 1'b1;
                end
            end
            FULL: begin
                if (buf_release) begin
                    state_d     = FILL;
                    acc_cnt_d   = '0;
                    wr_idx_d    = '0;
                    sat_count_d = '0;
                    buf_full_d  = 1'b0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase

        rd_data_d = '0;
        if (rd_addr < IDX_W'(NODES)) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FILL;
            acc_cnt_q    <= '0;
            wr_idx_q     <= '0;
            max_idx_q    <= '0;
            max_val_q    <= '0;
            rd_data_q    <= '0;
            buf_full_q   <= 1'b0;
            layer_done_q <= 1'b0;
            sat_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            acc_cnt_q    <= acc_cnt_d;
            wr_idx_q     <= wr_idx_d;
            max_idx_q    <= max_idx_d;
            max_val_q    <= max_val_d;
            rd_data_q    <= rd_data_d;
            buf_full_q   <= buf_full_d;
            layer_done_q <= layer_done_d;
            sat_count_q  <= sat_count_d;
        end
    end

    // Activation storage is deliberately left without reset.
    always_ff @(posedge clk) begin
        if (p_valid) begin
            mem[wr_idx_q] <= p_data;
        end
    end

    assign rd_data    = rd_data_q;
    assign buf_full   = buf_full_q;
    assign layer_done = layer_done_q;
    assign max_idx    = max_idx_q;
    assign max_val    = max_val_q;
    assign sat_count  = sat_count_q;

endmodule
`default_nettype wire
